// File: rtl/vga_hex_scanner.sv
// vga_hex_scanner: 640x480@60 raster timing, hex slot selection for the
// seven-segment renderer, and a registered RGB332 pixel stage with aligned syncs.
module vga_hex_scanner #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned ORIGIN_X  = 100,
  parameter int unsigned ORIGIN_Y  = 100,
  parameter int unsigned PITCH     = 80,
  parameter logic [7:0]  FG        = 8'hFF,
  parameter logic [7:0]  BG        = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  value_valid,
  output logic [10:0]           x,
  output logic [10:0]           y,
  output logic [10:0]           cx,
  output logic [10:0]           cy,
  output logic [3:0]            digit,
  input  logic                  hit,
  output logic [7:0]            rgb,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int unsigned CW        = 11;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned WORD_W    = 4 * DIGITS;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START  = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END    = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END    = VS_START + V_SYNC;
  localparam int unsigned WIN_START = ORIGIN_X - PITCH / 2;

  localparam logic [CW-1:0]    H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    WIN_C      = CW'(WIN_START);
  localparam logic [CW-1:0]    PITCH_C    = CW'(PITCH);
  localparam logic [CW-1:0]    PITCH_LAST = CW'(PITCH - 1);
  localparam logic [CW-1:0]    ORIGIN_X_C = CW'(ORIGIN_X);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [CW-1:0]     h_cnt, v_cnt, h_next;
  logic              h_wrap, frame_end, visible;
  logic [WORD_W-1:0] shadow, shadow_next;
  logic              slot_active, slot_active_n;
  logic [IDX_W-1:0]  slot_idx, slot_idx_n;
  logic [CW-1:0]     slot_pos, slot_pos_n;
  logic [CW-1:0]     cx_n;
  logic [3:0]        digit_n;

  // Slot k shows nibble DIGITS-1-k, so slot 0 is the most significant digit.
  function automatic logic [3:0] nib(input logic [WORD_W-1:0] w, input logic [IDX_W-1:0] k);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < int'(DIGITS); i++)
      if (IDX_W'(i) == k) r = w[4*(int'(DIGITS)-1-i) +: 4];
    return r;
  endfunction

  assign h_wrap      = (h_cnt == H_LAST);
  assign h_next      = h_wrap ? '0 : h_cnt + CW'(1);
  assign frame_end   = h_wrap && (v_cnt == V_LAST);
  assign shadow_next = (frame_end && value_valid) ? value_in : shadow;
  assign visible     = (h_cnt < CW'(H_VISIBLE)) && (v_cnt < CW'(V_VISIBLE));

  assign x  = h_cnt;
  assign y  = v_cnt;
  assign cy = CW'(ORIGIN_Y);

  // Raster counters: column wraps at H_TOTAL, row steps on column wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_next;
      if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
    end
  end

  // Displayed word is captured only at the last pixel of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow <= '0;
    else     shadow <= shadow_next;
  end

  // Next slot state from the next column, so slot outputs line up with x.
  always_comb begin
    slot_active_n = slot_active;
    slot_idx_n    = slot_idx;
    slot_pos_n    = slot_pos;
    cx_n          = cx;
    digit_n       = digit;
    if (h_next == WIN_C) begin
      slot_active_n = 1'b1;
      slot_idx_n    = '0;
      slot_pos_n    = '0;
      cx_n          = ORIGIN_X_C;
      digit_n       = nib(shadow_next, '0);
    end else if (h_wrap) begin
      slot_active_n = 1'b0;
    end else if (slot_active) begin
      if (slot_pos == PITCH_LAST) begin
        slot_pos_n = '0;
        if (slot_idx == IDX_LAST) begin
          slot_active_n = 1'b0;
        end else begin
          slot_idx_n = slot_idx + IDX_W'(1);
          cx_n       = cx + PITCH_C;
          digit_n    = nib(shadow_next, slot_idx + IDX_W'(1));
        end
      end else begin
        slot_pos_n = slot_pos + CW'(1);
      end
    end
  end

  // Slot tracking registers; a window starting at column 0 is active out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_active <= (WIN_START == 0);
      slot_idx    <= '0;
      slot_pos    <= '0;
      cx          <= ORIGIN_X_C;
      digit       <= 4'h0;
    end else begin
      slot_active <= slot_active_n;
      slot_idx    <= slot_idx_n;
      slot_pos    <= slot_pos_n;
      cx          <= cx_n;
      digit       <= digit_n;
    end
  end

  // Pixel stage: colour and syncs one cycle behind the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb         <= 8'h00;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rgb         <= visible ? ((slot_active && hit) ? FG : BG) : 8'h00;
      hsync       <= !((h_cnt >= CW'(HS_START)) && (h_cnt < CW'(HS_END)));
      vsync       <= !((v_cnt >= CW'(VS_START)) && (v_cnt < CW'(VS_END)));
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_hex_scanner.sv
// Testbench for vga_hex_scanner: full horizontal timing, shortened vertical
// timing (12 lines, 9600-cycle frame) to keep the run short.
module tb_vga_hex_scanner;

  localparam logic [7:0] FGC = 8'hE0;
  localparam logic [7:0] BGC = 8'h1C;
  localparam int FRAME = 800 * 12;

  logic        clk, rst;
  logic [15:0] value_in;
  logic        value_valid, hit;
  logic [10:0] x, y, cx, cy;
  logic [3:0]  digit;
  logic [7:0]  rgb;
  logic        hsync, vsync, frame_start;

  int n_cmp = 0;
  int n_fail = 0;

  vga_hex_scanner #(
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .FG(FGC), .BG(BGC)
  ) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .value_valid(value_valid),
    .x(x), .y(y), .cx(cx), .cy(cy), .digit(digit), .hit(hit),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         px;
    int         py;
    logic       chk_slot;
    logic [3:0] dig;
    int         ccx;
    logic [7:0] col;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance on falling edges until the beam is at (tx,ty), bounded.
  task automatic wait_xy(input int tx, input int ty);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (int'(x) == tx && int'(y) == ty) break;
      @(negedge clk);
    end
    check($sformatf("reach(%0d,%0d)", tx, ty), {5'b0, y, 5'b0, x}, {5'b0, 11'(ty), 5'b0, 11'(tx)});
  endtask

  // Slot outputs at (tx,ty), then the pixel colour one cycle later.
  task automatic probe(input int tx, input int ty, input logic chk_slot,
                       input logic [3:0] dg, input int ccx, input logic [7:0] col);
    wait_xy(tx, ty);
    if (chk_slot) begin
      check($sformatf("digit(%0d,%0d)", tx, ty), 32'(digit), 32'(dg));
      check($sformatf("cx(%0d,%0d)", tx, ty), 32'(cx), 32'(ccx));
      check($sformatf("cy(%0d,%0d)", tx, ty), 32'(cy), 32'd100);
    end
    @(negedge clk);
    check($sformatf("rgb(%0d,%0d)", tx, ty), 32'(rgb), 32'(col));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_rgb"}, 32'(rgb), 0);
    check({tag, "_hsync"}, 32'(hsync), 1);
    check({tag, "_vsync"}, 32'(vsync), 1);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_cx"}, 32'(cx), 100);
    check({tag, "_digit"}, 32'(digit), 0);
  endtask

  initial begin
    int cyc, hs_low, hs_bad, hs_first, vs_low, vs_bad, px, py;
    logic fs_seen;

    tbl[0]  = '{59,  1, 1'b0, 4'h0, 0,   BGC};
    tbl[1]  = '{60,  1, 1'b1, 4'h1, 100, FGC};
    tbl[2]  = '{139, 1, 1'b1, 4'h1, 100, FGC};
    tbl[3]  = '{140, 1, 1'b1, 4'hA, 180, FGC};
    tbl[4]  = '{150, 1, 1'b1, 4'hA, 180, FGC};
    tbl[5]  = '{220, 2, 1'b1, 4'h3, 260, FGC};
    tbl[6]  = '{379, 2, 1'b1, 4'hF, 340, FGC};
    tbl[7]  = '{380, 2, 1'b0, 4'h0, 0,   BGC};
    tbl[8]  = '{639, 3, 1'b0, 4'h0, 0,   BGC};
    tbl[9]  = '{640, 3, 1'b0, 4'h0, 0,   8'h00};
    tbl[10] = '{150, 6, 1'b1, 4'hA, 180, 8'h00};

    rst = 1'b1; value_in = 16'h1A3F; value_valid = 1'b0; hit = 1'b1;
    #1;
    check_reset_outputs("rst0");
    repeat (3) @(negedge clk);
    check_reset_outputs("rst1");
    rst = 1'b0;

    // frame_start at the first cycle after release, then once per frame
    @(negedge clk);
    check("fs_first", 32'(frame_start), 1);
    check("x_first", 32'(x), 1);
    cyc = 0; fs_seen = 1'b0;
    while (cyc < 2 * FRAME && !fs_seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 100) value_valid = 1'b1;
      fs_seen = frame_start;
    end
    check("fs_period", 32'(cyc), 32'(FRAME));

    // frame 1: 16'h1A3F captured at the previous frame boundary
    foreach (tbl[i])
      probe(tbl[i].px, tbl[i].py, tbl[i].chk_slot, tbl[i].dig, tbl[i].ccx, tbl[i].col);

    // frame 1 continued: horizontal sync shape over one line
    wait_xy(0, 7);
    hs_low = 0; hs_bad = 0; hs_first = -1;
    for (int i = 0; i < 800; i++) begin
      px = int'(x);
      @(negedge clk);
      if (hsync !== !(px >= 656 && px < 752)) hs_bad++;
      if (hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = px;
      end
    end
    check("hsync_bad", 32'(hs_bad), 0);
    check("hsync_width", 32'(hs_low), 96);
    check("hsync_first_x", 32'(hs_first), 656);

    // vertical sync over lines 8..11
    vs_low = 0; vs_bad = 0;
    for (int i = 0; i < 3200; i++) begin
      py = int'(y);
      @(negedge clk);
      if (vsync !== !(py >= 8 && py < 10)) vs_bad++;
      if (vsync === 1'b0) vs_low++;
    end
    check("vsync_bad", 32'(vs_bad), 0);
    check("vsync_width", 32'(vs_low), 1600);

    // frame 2: mid-frame change to 0 has no visible effect this frame
    probe(150, 1, 1'b1, 4'hA, 180, FGC);
    wait_xy(0, 2);
    value_in = 16'h0000;
    probe(150, 4, 1'b1, 4'hA, 180, FGC);
    probe(379, 5, 1'b1, 4'hF, 340, FGC);

    // frame 3: new word from the first line
    probe(60, 0, 1'b1, 4'h0, 100, FGC);
    probe(300, 1, 1'b1, 4'h0, 340, FGC);
    value_in = 16'hBEEF; value_valid = 1'b0;

    // frame 4: value_valid low, old word retained
    probe(150, 1, 1'b1, 4'h0, 180, FGC);
    value_valid = 1'b1;

    // frame 5: BEEF shown, then reset mid-line
    probe(150, 1, 1'b1, 4'hE, 180, FGC);
    wait_xy(300, 1);
    check("pre_rst_digit", 32'(digit), 32'hF);
    rst = 1'b1; value_valid = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("fs_after_rst", 32'(frame_start), 1);
    check("x_after_rst", 32'(x), 1);
    probe(150, 1, 1'b1, 4'h0, 180, FGC);
    probe(300, 1, 1'b1, 4'h0, 340, FGC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_hex_scanner.md
# vga_hex_scanner

Upstream driver for the seven-segment digit renderer: generates 640x480@60 VGA raster timing and presents each pixel's scan coordinate. Also selects the hex digit slot under the beam and provides that slot's nibble and centre point to the renderer. It consumes the renderer's `hit` result one cycle later and emits registered RGB332 pixels with sync aligned to them. The displayed word is snapshotted once per frame so a digit never changes mid-frame.

## Interface
Parameters:
- `H_VISIBLE` 640, `H_FRONT` 16, `H_SYNC` 96, `H_BACK` 48 – horizontal timing in pixels; `H_TOTAL` = sum (800)
- `V_VISIBLE` 480, `V_FRONT` 10, `V_SYNC` 2, `V_BACK` 33 – vertical timing in lines; `V_TOTAL` = sum (525)
- `DIGITS` 4 – number of hex slots, 1..8; the word width is 4*`DIGITS`
- `ORIGIN_X` 100, `ORIGIN_Y` 100 – centre of slot 0 (most significant nibble); requires `ORIGIN_X` >= `PITCH`/2
- `PITCH` 80 – horizontal spacing between slot centres; must be even
- `FG` 8'hFF, `BG` 8'h00 – RGB332 colours for a lit pixel and an unlit visible pixel

Ports:
- `clk` in 1 – pixel clock (25 MHz)
- `rst` in 1 – asynchronous, active-high reset
- `value_in` in 4*`DIGITS` – word to display
- `value_valid` in 1 – `value_in` is eligible for capture at the next frame start
- `x`, `y` out 11 – current scan column/row (raw counters, also valid in blanking)
- `cx`, `cy` out 11 – centre of the slot under the beam
- `digit` out 4 – nibble for that slot
- `hit` in 1 – renderer result for (`x`,`y`,`cx`,`cy`,`digit`) of the same cycle
- `rgb` out 8 – registered pixel colour
- `hsync`, `vsync` out 1 – active-low syncs, aligned with `rgb`
- `frame_start` out 1 – one-cycle pulse, aligned with `rgb`, on pixel (0,0)

## Operation
- Counters:
  - `h_cnt` runs 0..`H_TOTAL`-1 and wraps to 0.
  - `v_cnt` increments when `h_cnt` wraps and runs 0..`V_TOTAL`-1, then wraps to 0.
  - `x`=`h_cnt` and `y`=`v_cnt`, driven directly from the registers.
- Visible region: `h_cnt` < `H_VISIBLE` and `v_cnt` < `V_VISIBLE`.
- Sync intervals:
  - hsync is low for `h_cnt` in [`H_VISIBLE`+`H_FRONT`, +`H_SYNC`), i.e. [656,752).
  - vsync is low for `v_cnt` in [490,492).
- Slot window k spans x in [`ORIGIN_X`-`PITCH`/2 + k*`PITCH`, +`PITCH`) for k = 0..`DIGITS`-1; the defaults give [60,140), [140,220), [220,300), [300,380).
  - In window k: `cx`=`ORIGIN_X`+k*`PITCH`, `cy`=`ORIGIN_Y`, `digit`=nibble (`DIGITS`-1-k) of the shadow word, and `slot_active`=1.
  - Outside all windows: `slot_active`=0, and `cx`,`cy`,`digit` hold their last values (don't-care).
  - The slot index must come from an incremental per-line counter that restarts at `h_cnt`=0. No divider or multiplier may sit on the `x` path.
- Shadow word: on the cycle where `h_cnt`=`H_TOTAL`-1 and `v_cnt`=`V_TOTAL`-1, if `value_valid`=1 then shadow <= `value_in`; otherwise shadow is unchanged. `value_in` is ignored on all other cycles.
- Pixel stage (registered):
  - `rgb` <= `FG` if visible & `slot_active` & `hit`.
  - `rgb` <= `BG` if visible and not lit.
  - `rgb` <= 8'h00 in blanking.
  - `hsync`, `vsync` and `frame_start` are registered in the same stage.

## Timing
- Reset values:
  - `h_cnt`=`v_cnt`=0, so `x`=`y`=0.
  - shadow=0.
  - `cx`=`ORIGIN_X`, `cy`=`ORIGIN_Y`, `digit`=0.
  - `rgb`=0, `hsync`=`vsync`=1, `frame_start`=0.
- First clock after reset deassertion: the counters advance from (0,0).
- Latency: `rgb`/`hsync`/`vsync`/`frame_start` lag `x`/`y` by exactly 1 cycle. `frame_start`=1 on the cycle `rgb` shows pixel (0,0).
- `cx`/`cy`/`digit`/`slot_active` are valid in the same cycle as `x`, so the renderer's `hit` settles combinationally within that cycle.
- Reset mid-frame: all state returns to the reset values immediately (asynchronously). The next frame begins at (0,0) and shows value 0 until the next capture.
- Shadow update cadence:
  - The shadow changes only between frames, so a new word is visible from the first pixel of the next frame.
  - A `value_in` change mid-frame has no visible effect.
- Frame period: 800*525 = 420000 cycles.

## Test plan
- Reset held, then released: `rgb`=0, `hsync`=`vsync`=1 during reset. `frame_start` pulses at cycle 1 after release, then every 420000 cycles.
- Sync timing: `hsync` low for exactly 96 cycles starting when delayed `x`=656. `vsync` low for lines 490–491 only.
- `value_in`=16'h1A3F with `value_valid`=1 before the frame boundary, checked the next frame:
  - At `x`=150: `digit`=4'hA, `cx`=180.
  - At `x`=59: `slot_active`=0.
  - At `x`=379: `digit`=4'hF, `cx`=340.
  - At `x`=380: inactive.
- Mid-frame `value_in` change to 16'h0000 at `y`=200: digits stay 1,A,3,F for the rest of the frame and switch at the next (0,0). With `value_valid`=0 the old value is retained.
- `hit` forced 1: `rgb`=`FG` only in slot windows of the visible region, `BG` elsewhere visible, 0 in blanking. Check one cycle later than `x`.
- Assert `rst` at `x`=300, `y`=100: all outputs take their reset values immediately. After release the scan resumes from (0,0) with shadow=0.
